// File: rtl/step_ramp_generator.sv
// Trapezoidal step-rate generator: accepts a move command and emits step strobes
// whose spacing ramps from START_PERIOD down to a target period and back up.
module step_ramp_generator #(
  parameter int COUNT_W      = 16,
  parameter int PERIOD_W     = 24,
  parameter int START_PERIOD = 100000,
  parameter int MIN_PERIOD   = 20000,
  parameter int ACCEL_STEP   = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [COUNT_W-1:0]  cmd_steps,
  input  logic                cmd_reverse,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  output logic                step_pulse,
  output logic                reverse,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  steps_remaining
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEL  = 2'd1,
    CRUISE = 2'd2,
    DECEL  = 2'd3
  } state_t;

  // A floor of 2 keeps consecutive strobes at least one idle cycle apart.
  localparam int                MIN_EFF = (MIN_PERIOD < 2) ? 2 : MIN_PERIOD;
  localparam logic [PERIOD_W-1:0] START_P = PERIOD_W'(START_PERIOD);
  localparam logic [PERIOD_W-1:0] MIN_P   = PERIOD_W'(MIN_EFF);
  localparam logic [PERIOD_W:0]   ACC_X   = (PERIOD_W + 1)'(ACCEL_STEP);
  localparam logic [PERIOD_W:0]   START_X = {1'b0, START_P};

  function automatic logic [PERIOD_W-1:0] period_dec(input logic [PERIOD_W-1:0] cur,
                                                     input logic [PERIOD_W-1:0] floor_p);
    logic [PERIOD_W:0] cur_x;
    logic [PERIOD_W:0] floor_x;
    logic [PERIOD_W:0] diff_x;
    cur_x   = {1'b0, cur};
    floor_x = {1'b0, floor_p};
    diff_x  = cur_x - ACC_X;
    if (cur_x >= floor_x + ACC_X) begin
      period_dec = diff_x[PERIOD_W-1:0];
    end else begin
      period_dec = floor_p;
    end
  endfunction

  function automatic logic [PERIOD_W-1:0] period_inc(input logic [PERIOD_W-1:0] cur);
    logic [PERIOD_W:0] sum_x;
    sum_x = {1'b0, cur} + ACC_X;
    if (sum_x >= START_X) begin
      period_inc = START_P;
    end else begin
      period_inc = sum_x[PERIOD_W-1:0];
    end
  endfunction

  state_t              state_q, state_d;
  logic [COUNT_W-1:0]  steps_q, steps_d;
  logic [COUNT_W-1:0]  ramp_q, ramp_d;
  logic [PERIOD_W-1:0] cur_q, cur_d;
  logic [PERIOD_W-1:0] target_q, target_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic                reverse_q, reverse_d;
  logic                done_q, done_d;

  logic                fire_s;
  logic [PERIOD_W-1:0] clamp_s;
  logic [COUNT_W-1:0]  steps_left_s;
  logic [COUNT_W-1:0]  step_ramp_s;
  logic [PERIOD_W-1:0] step_cur_s;
  state_t              step_state_s;

  // An abort sampled in the due cycle cancels that strobe outright.
  assign fire_s = (state_q != IDLE) && (timer_q == '0) && !abort;

  assign cmd_ready       = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign step_pulse      = fire_s;
  assign done            = done_q | (fire_s && (steps_q == COUNT_W'(1)));
  assign reverse         = reverse_q;
  assign steps_remaining = steps_q;

  // Next-state, profile and timer computation.
  always_comb begin
    state_d      = state_q;
    steps_d      = steps_q;
    ramp_d       = ramp_q;
    cur_d        = cur_q;
    target_d     = target_q;
    timer_d      = timer_q;
    reverse_d    = reverse_q;
    done_d       = 1'b0;
    steps_left_s = steps_q - COUNT_W'(1);
    step_ramp_s  = ramp_q;
    step_cur_s   = cur_q;
    step_state_s = state_q;

    if (cmd_period < MIN_P) begin
      clamp_s = MIN_P;
    end else if (cmd_period > START_P) begin
      clamp_s = START_P;
    end else begin
      clamp_s = cmd_period;
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          reverse_d = cmd_reverse;
          steps_d   = cmd_steps;
          ramp_d    = '0;
          cur_d     = START_P;
          target_d  = clamp_s;
          timer_d   = START_P - PERIOD_W'(1);
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else if (clamp_s < START_P) begin
            state_d = ACCEL;
          end else begin
            state_d = CRUISE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        if (abort) begin
          state_d = IDLE;
          steps_d = '0;
          done_d  = 1'b1;
        end else if (timer_q != '0) begin
          timer_d = timer_q - PERIOD_W'(1);
        end else begin
          if (state_q == ACCEL) begin
            step_cur_s  = period_dec(cur_q, target_q);
            step_ramp_s = ramp_q + COUNT_W'(1);
            if (step_cur_s == target_q) begin
              step_state_s = CRUISE;
            end else begin
              step_state_s = ACCEL;
            end
          end else begin
            step_state_s = state_q;
          end
          // Start slowing once the remaining steps can just unwind the ramp.
          if (state_q == DECEL) begin
            step_cur_s = period_inc(cur_q);
          end else if ((steps_left_s != '0) && (steps_left_s <= step_ramp_s)) begin
            step_state_s = DECEL;
            step_cur_s   = period_inc(step_cur_s);
          end else begin
            step_state_s = step_state_s;
          end
          if (steps_left_s == '0) begin
            step_state_s = IDLE;
          end else begin
            step_state_s = step_state_s;
          end
          state_d = step_state_s;
          steps_d = steps_left_s;
          ramp_d  = step_ramp_s;
          cur_d   = step_cur_s;
          timer_d = step_cur_s - PERIOD_W'(1);
        end
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      steps_q   <= '0;
      ramp_q    <= '0;
      cur_q     <= '0;
      target_q  <= '0;
      timer_q   <= '0;
      reverse_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      steps_q   <= steps_d;
      ramp_q    <= ramp_d;
      cur_q     <= cur_d;
      target_q  <= target_d;
      timer_q   <= timer_d;
      reverse_q <= reverse_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_step_ramp_generator.sv
// Self-checking bench for step_ramp_generator with a small integer ramp model.
module tb_step_ramp_generator;

  localparam int SP = 10;
  localparam int MP = 4;
  localparam int AS = 2;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_steps;
  logic        cmd_reverse;
  logic [23:0] cmd_period;
  logic        abort;
  logic        step_pulse;
  logic        reverse;
  logic        busy;
  logic        done;
  logic [15:0] steps_remaining;

  int n_checks;
  int n_errors;
  int exp_t[$];

  step_ramp_generator #(
    .COUNT_W(16), .PERIOD_W(24), .START_PERIOD(SP), .MIN_PERIOD(MP), .ACCEL_STEP(AS)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_reverse(cmd_reverse), .cmd_period(cmd_period),
    .abort(abort), .step_pulse(step_pulse), .reverse(reverse), .busy(busy),
    .done(done), .steps_remaining(steps_remaining)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse times (cycles after the handshake cycle) for a move, from the ramp rules.
  task automatic model_pulses(input int steps, input int period);
    int tgt, cur, ramp, t, left;
    bit speeding, slowing;
    exp_t.delete();
    tgt = (period < MP) ? MP : ((period > SP) ? SP : period);
    cur = SP; ramp = 0; t = SP;
    speeding = (tgt < SP);
    slowing = 1'b0;
    for (int i = 1; i <= steps; i++) begin
      exp_t.push_back(t);
      left = steps - i;
      if (left == 0) break;
      if (slowing) begin
        cur = (cur + AS > SP) ? SP : cur + AS;
      end else begin
        if (speeding) begin
          cur = (cur - AS < tgt) ? tgt : cur - AS;
          ramp++;
          if (cur == tgt) speeding = 1'b0;
        end
        if (left <= ramp) begin
          slowing = 1'b1;
          cur = (cur + AS > SP) ? SP : cur + AS;
        end
      end
      t += cur;
    end
  endtask

  // Issues one command (expected pulses in exp_t) and checks every cycle of it.
  task automatic run_move(input int steps, input bit rev, input int period,
                          input int abort_at, input string tag);
    int pulses[$];
    int done_c, busy_end, horizon, issued, exp_rem;
    bit aborted, exp_pulse;
    pulses = exp_t;
    aborted = 1'b0;
    if (steps > 0 && abort_at >= 1 && abort_at <= pulses[pulses.size()-1]) begin
      aborted = 1'b1;
      while (pulses.size() > 0 && pulses[pulses.size()-1] >= abort_at) void'(pulses.pop_back());
      done_c = abort_at + 1;
      busy_end = abort_at;
    end else if (steps == 0) begin
      done_c = 1;
      busy_end = 0;
    end else begin
      done_c = pulses[pulses.size()-1];
      busy_end = done_c;
    end
    horizon = done_c + 3;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_steps = 16'(steps); cmd_reverse = rev;
    cmd_period = 24'(period); abort = 1'b0;
    for (int c = 0; c <= horizon; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL %s ready_at_cmd got=%b exp=1", tag, cmd_ready);
      end else begin
        exp_pulse = 1'b0; issued = 0;
        foreach (pulses[k]) begin
          if (pulses[k] == c) exp_pulse = 1'b1;
          if (pulses[k] < c) issued++;
        end
        exp_rem = (aborted && c > abort_at) ? 0 : steps - issued;
        n_checks++;
        if (step_pulse !== exp_pulse) begin
          n_errors++; $display("FAIL %s step_pulse c=%0d got=%b exp=%b", tag, c, step_pulse, exp_pulse);
        end
        n_checks++;
        if (done !== (c == done_c)) begin
          n_errors++; $display("FAIL %s done c=%0d got=%b exp=%b", tag, c, done, (c == done_c));
        end
        n_checks++;
        if (busy !== (c <= busy_end) || cmd_ready !== (c > busy_end)) begin
          n_errors++; $display("FAIL %s busy/ready c=%0d got=%b/%b exp_busy=%b", tag, c, busy, cmd_ready, (c <= busy_end));
        end
        n_checks++;
        if (reverse !== rev) begin
          n_errors++; $display("FAIL %s reverse c=%0d got=%b exp=%b", tag, c, reverse, rev);
        end
        n_checks++;
        if (steps_remaining !== 16'(exp_rem)) begin
          n_errors++; $display("FAIL %s steps_remaining c=%0d got=%0d exp=%0d", tag, c, steps_remaining, exp_rem);
        end
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      abort = (c + 1 == abort_at);
    end
    abort = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({step_pulse, done, busy, reverse} !== 4'b0000 || steps_remaining !== 16'd0) begin
      n_errors++; $display("FAIL reset_outputs got=%b%b%b%b rem=%0d exp=0", step_pulse, done, busy, reverse, steps_remaining);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_release ready=%b busy=%b exp=1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_spec_vectors();
    exp_t = '{10, 18, 24, 28, 32, 36, 40, 46, 54, 64};
    run_move(10, 1'b0, 4, 0, "ramp10");
    exp_t = '{10, 18, 26};
    run_move(3, 1'b0, 4, 0, "ramp3");
    exp_t = '{10, 20, 30, 40};
    run_move(4, 1'b1, 50, 0, "cruise4");
  endtask

  task automatic test_zero_steps();
    exp_t.delete();
    run_move(0, 1'b1, 4, 0, "zero");
  endtask

  task automatic test_abort();
    exp_t = '{10, 18, 24, 28, 32, 36, 40, 46, 54, 64};
    run_move(10, 1'b1, 4, 20, "abort20");
    exp_t = '{10, 18, 24};
    run_move(3, 1'b0, 6, 18, "abort_on_pulse");
  endtask

  task automatic test_reset_mid_move();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_steps = 16'd10; cmd_reverse = 1'b1; cmd_period = 24'd4;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++; $display("FAIL midreset_busy_before got=%b exp=1", busy);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({step_pulse, done, busy, reverse} !== 4'b0000 || steps_remaining !== 16'd0) begin
      n_errors++; $display("FAIL midreset_outputs got=%b%b%b%b rem=%0d exp=0", step_pulse, done, busy, reverse, steps_remaining);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      n_checks++;
      if (step_pulse !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        n_errors++; $display("FAIL midreset_quiet c=%0d pulse=%b done=%b busy=%b exp=0", c, step_pulse, done, busy);
      end
    end
    model_pulses(3, 4);
    run_move(3, 1'b0, 4, 0, "after_reset");
  endtask

  task automatic test_random();
    int steps, period, abort_at;
    bit rev;
    for (int m = 0; m < 16; m++) begin
      steps  = $urandom_range(0, 14);
      period = $urandom_range(0, 30);
      rev    = 1'($urandom_range(0, 1));
      abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 90) : 0;
      model_pulses(steps, period);
      run_move(steps, rev, period, abort_at, "random");
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_steps = 16'd0; cmd_reverse = 1'b0;
    cmd_period = 24'd0; abort = 1'b0;
    test_reset();
    test_spec_vectors();
    test_zero_steps();
    test_abort();
    test_reset_mid_move();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
